dvi_timing_rx: RTL and testbench
================================

// Module: dvi_timing_rx
// PURPOSE
//  Receive-side timing recovery for the 640x480@60 DVI/VGA video path.
//  Samples incoming hsync/vsync/display_on and regenerates pixel x/y coordinates.
//  Measures line and frame lengths and declares lock once the stream matches the
//  expected raster for LOCK_FRAMES consecutive frames.
//  Sits after the sink-side sync decoder; feeds capture/overlay logic in the pixel domain.
// PARAMETERS
//  H_RES       640  active pixels per line
//  V_RES       480  active lines per frame
//  H_TOTAL     800  expected clocks per line (hsync edge to hsync edge)
//  V_TOTAL     525  expected lines per frame (vsync edge to vsync edge)
//  HSYNC_POL   0    asserted level of hsync (0 = active-low)
//  VSYNC_POL   0    asserted level of vsync (0 = active-low)
//  LOCK_FRAMES 2    consecutive matching frames required to lock (>=1)
//  Derived widths: X_W=$clog2(H_RES+1), Y_W=$clog2(V_RES+1), HS_W=$clog2(2*H_TOTAL+1), VS_W=$clog2(2*V_TOTAL+1)
// PORTS
//  clk          in   1     pixel clock
//  rst          in   1     synchronous reset, active-high
//  hsync        in   1     incoming horizontal sync
//  vsync        in   1     incoming vertical sync
//  display_on   in   1     incoming data-enable (active video)
//  x            out  X_W   active-pixel column of current sample
//  y            out  Y_W   active-line row of current sample
//  pixel_valid  out  1     display_on, aligned with x/y
//  line_start   out  1     1-cycle pulse on hsync asserting edge
//  frame_start  out  1     1-cycle pulse on vsync asserting edge
//  line_len     out  HS_W  last measured line length in clocks
//  frame_lines  out  VS_W  last measured frame length in lines
//  locked       out  1     raster matches expected timing
//  timing_err   out  1     1-cycle pulse on a mismatch while locked
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=SEARCH; all counters, match_cnt and previous-sample regs 0.
//  - Inputs registered once. Polarity is normalised via *_POL. Edge = normalised asserted now and not asserted on the previous registered sample.
//  - All outputs are registered: 1 cycle after the registered sample, i.e. 2 clks after the input pin.
//  - h_cnt: counts clocks since last hsync edge; saturates at 2*H_TOTAL.
//    - On hsync edge: line_len <= h_cnt+1 (saturating), h_cnt <= 0.
//  - x: 0 while display_on low; increments per display_on-high clock; cleared on hsync edge; saturates at H_RES.
//  - v_cnt: incremented on each hsync edge. On vsync edge: frame_lines <= v_cnt, v_cnt <= 0.
//    - An hsync edge coincident with a vsync edge counts as line 0 of the new frame.
//  - y: counts lines that contained display_on since vsync edge; increments on the first hsync edge after such a line; cleared on vsync edge; saturates at V_RES.
//  - line_ok flag: set at vsync edge; cleared by any hsync edge with length != H_TOTAL in that frame.
//  - Frame match: line_ok and v_cnt == V_TOTAL at vsync edge.
//  - FSM:
//    - SEARCH: on vsync edge -> TRACK, match_cnt=0.
//    - TRACK: on vsync edge with frame match, match_cnt++; when it reaches LOCK_FRAMES -> LOCKED.
//      Mismatch: match_cnt=0, stay in TRACK.
//    - LOCKED: locked=1. Leaving LOCKED for either reason below deasserts locked on the next cycle.
//      - hsync edge with length != H_TOTAL, or vsync edge with v_cnt != V_TOTAL: pulse timing_err, -> TRACK, match_cnt=0.
//    - Any state: h_cnt saturated (no hsync for 2*H_TOTAL clks) or v_cnt reaching 2*V_TOTAL -> SEARCH.
//      If this happens in LOCKED, also pulse timing_err.
//  - The first partial line/frame after reset or SEARCH is never used for matching.
//  - rst mid-frame: immediate return to the reset state; the next vsync edge restarts acquisition.
// TESTING
//  - Clean 800x525 raster, 640x480 active -> locked=1 exactly at the 3rd vsync edge (LOCK_FRAMES=2); x spans 0..639, y spans 0..479.
//  - Locked; one line shortened to 799 clks -> line_len=799, timing_err pulses once, locked=0.
//    - Then relocks after 2 further clean frames.
//  - Locked; frame with 526 lines -> frame_lines=526, timing_err pulse, locked drops at that vsync edge.
//  - hsync held deasserted 1600 clks -> FSM in SEARCH, locked=0; clean restart relocks after 3 vsync edges.
//  - HSYNC_POL=1/VSYNC_POL=1 with positive syncs -> same lock timing as the first scenario.
//    - Inverted syncs -> line_len/frame_lines still measured edge-to-edge, so lock is achieved but x/y phase is shifted.
//  - rst asserted mid-line while locked -> next clk all outputs 0; locked only after 3 vsync edges.

Source files
------------

// File: rtl/dvi_timing_rx.sv
// Receive-side timing recovery for a DVI/VGA raster.
// Registers the incoming syncs and data-enable, regenerates x/y coordinates,
// measures line and frame lengths and declares lock after LOCK_FRAMES
// consecutive frames that match the expected raster.
// Ports:
//   clk, rst                   pixel clock, synchronous active-high reset
//   hsync, vsync, display_on   incoming sync and data-enable
//   x, y, pixel_valid          coordinates of the current sample, data-enable
//   line_start, frame_start    one-cycle pulses on sync asserting edges
//   line_len, frame_lines      last measured line length (clks) / frame length (lines)
//   locked, timing_err         lock status, one-cycle pulse on a loss of timing while locked
module dvi_timing_rx #(
   parameter int unsigned H_RES       = 640,
   parameter int unsigned V_RES       = 480,
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned V_TOTAL     = 525,
   parameter bit          HSYNC_POL   = 1'b0,
   parameter bit          VSYNC_POL   = 1'b0,
   parameter int unsigned LOCK_FRAMES = 2,
   localparam int unsigned X_W  = $clog2(H_RES + 1),
   localparam int unsigned Y_W  = $clog2(V_RES + 1),
   localparam int unsigned HS_W = $clog2(2 * H_TOTAL + 1),
   localparam int unsigned VS_W = $clog2(2 * V_TOTAL + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hsync,
   input  logic            vsync,
   input  logic            display_on,
   output logic [X_W-1:0]  x,
   output logic [Y_W-1:0]  y,
   output logic            pixel_valid,
   output logic            line_start,
   output logic            frame_start,
   output logic [HS_W-1:0] line_len,
   output logic [VS_W-1:0] frame_lines,
   output logic            locked,
   output logic            timing_err
);

   localparam int unsigned MC_W = $clog2(LOCK_FRAMES + 1);

   localparam logic [HS_W-1:0] H_SAT   = HS_W'(2 * H_TOTAL);
   localparam logic [HS_W-1:0] H_TOT_C = HS_W'(H_TOTAL);
   localparam logic [VS_W-1:0] V_SAT   = VS_W'(2 * V_TOTAL);
   localparam logic [VS_W-1:0] V_TOT_C = VS_W'(V_TOTAL);
   localparam logic [X_W-1:0]  X_MAX   = X_W'(H_RES);
   localparam logic [Y_W-1:0]  Y_MAX   = Y_W'(V_RES);
   localparam logic [MC_W-1:0] LOCK_C  = MC_W'(LOCK_FRAMES);

   typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCKED} state_t;

   state_t          state;
   logic            hs_smp, vs_smp, de_smp;
   logic            hs_prev, vs_prev;
   logic [HS_W-1:0] h_cnt;
   logic [VS_W-1:0] v_cnt;
   logic [X_W-1:0]  x_cnt;
   logic [MC_W-1:0] match_cnt;
   logic            line_de;
   logic            line_ok;
   logic            h_seen;

   logic            hs_edge, vs_edge;
   logic [HS_W-1:0] len_now;
   logic            line_bad, h_lost, v_lost, frame_ok;

   // Edge detection, measurement and loss-of-sync decode on the registered sample
   always_comb begin
      hs_edge  = hs_smp & ~hs_prev;
      vs_edge  = vs_smp & ~vs_prev;
      len_now  = (h_cnt == H_SAT) ? H_SAT : h_cnt + HS_W'(1);
      // h_seen masks the partial first line after reset or loss of sync
      line_bad = hs_edge & h_seen & (len_now != H_TOT_C);
      h_lost   = (h_cnt == H_SAT) & ~hs_edge;
      v_lost   = (v_cnt == V_SAT) & ~vs_edge;
      // A line ending on the vsync edge still belongs to the frame being closed
      frame_ok = line_ok & ~line_bad & (v_cnt == V_TOT_C);
   end

   // Sampling, counters and acquisition FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_SEARCH;
         hs_smp      <= 1'b0;
         vs_smp      <= 1'b0;
         de_smp      <= 1'b0;
         hs_prev     <= 1'b0;
         vs_prev     <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         x_cnt       <= '0;
         match_cnt   <= '0;
         line_de     <= 1'b0;
         line_ok     <= 1'b0;
         h_seen      <= 1'b0;
         x           <= '0;
         y           <= '0;
         pixel_valid <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         line_len    <= '0;
         frame_lines <= '0;
         locked      <= 1'b0;
         timing_err  <= 1'b0;
      end else begin
         // Polarity is normalised before the sample register so 1 always means asserted
         hs_smp  <= (hsync == HSYNC_POL);
         vs_smp  <= (vsync == VSYNC_POL);
         de_smp  <= display_on;
         hs_prev <= hs_smp;
         vs_prev <= vs_smp;

         line_start  <= hs_edge;
         frame_start <= vs_edge;
         pixel_valid <= de_smp;

         if (hs_edge) begin
            h_cnt    <= '0;
            line_len <= len_now;
         end else if (h_cnt != H_SAT) begin
            h_cnt <= h_cnt + HS_W'(1);
         end

         // x_cnt holds the column of the next active pixel
         if (hs_edge) begin
            x_cnt <= de_smp ? X_W'(1) : '0;
         end else if (de_smp && (x_cnt != X_MAX)) begin
            x_cnt <= x_cnt + X_W'(1);
         end
         x <= (de_smp && !hs_edge) ? x_cnt : '0;

         if (hs_edge) begin
            line_de <= de_smp;
         end else if (de_smp) begin
            line_de <= 1'b1;
         end

         if (vs_edge) begin
            y <= '0;
         end else if (hs_edge && line_de && (y != Y_MAX)) begin
            y <= y + Y_W'(1);
         end

         // A coincident hsync edge is line 0 of the new frame, so it is counted there
         if (vs_edge) begin
            frame_lines <= v_cnt;
            v_cnt       <= hs_edge ? VS_W'(1) : '0;
         end else if (hs_edge && (v_cnt != V_SAT)) begin
            v_cnt <= v_cnt + VS_W'(1);
         end

         if (vs_edge) begin
            line_ok <= 1'b1;
         end else if (line_bad) begin
            line_ok <= 1'b0;
         end

         if (h_lost) begin
            h_seen <= 1'b0;
         end else if (hs_edge) begin
            h_seen <= 1'b1;
         end

         timing_err <= 1'b0;
         if (h_lost || v_lost) begin
            timing_err <= (state == ST_LOCKED);
            state      <= ST_SEARCH;
            match_cnt  <= '0;
            locked     <= 1'b0;
         end else begin
            case (state)
               ST_SEARCH: begin
                  if (vs_edge) begin
                     state     <= ST_TRACK;
                     match_cnt <= '0;
                  end
               end
               ST_TRACK: begin
                  if (vs_edge) begin
                     if (!frame_ok) begin
                        match_cnt <= '0;
                     end else if (match_cnt == LOCK_C - MC_W'(1)) begin
                        state     <= ST_LOCKED;
                        match_cnt <= '0;
                        locked    <= 1'b1;
                     end else begin
                        match_cnt <= match_cnt + MC_W'(1);
                     end
                  end
               end
               ST_LOCKED: begin
                  if (line_bad || (vs_edge && (v_cnt != V_TOT_C))) begin
                     timing_err <= 1'b1;
                     state      <= ST_TRACK;
                     match_cnt  <= '0;
                     locked     <= 1'b0;
                  end
               end
               default: begin
                  state     <= ST_SEARCH;
                  match_cnt <= '0;
                  locked    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dvi_timing_rx.sv
// Directed bench for dvi_timing_rx on a reduced 24x12 raster (16x8 active).
// A second instance with positive sync polarity sees the inverted syncs, or the
// raw syncs when inv is set.
module tb_dvi_timing_rx;

   localparam int H_RES   = 16;
   localparam int V_RES   = 8;
   localparam int H_TOTAL = 24;
   localparam int V_TOTAL = 12;
   localparam int X_W  = $clog2(H_RES + 1);
   localparam int Y_W  = $clog2(V_RES + 1);
   localparam int HS_W = $clog2(2 * H_TOTAL + 1);
   localparam int VS_W = $clog2(2 * V_TOTAL + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, hsync, vsync, display_on, inv, clr;
   logic pol_hsync, pol_vsync;
   assign pol_hsync = inv ? hsync : ~hsync;
   assign pol_vsync = inv ? vsync : ~vsync;

   logic [X_W-1:0]  x, pol_x;
   logic [Y_W-1:0]  y, pol_y;
   logic            pixel_valid, line_start, frame_start, locked, timing_err;
   logic            pol_pixel_valid, pol_line_start, pol_frame_start, pol_locked, pol_timing_err;
   logic [HS_W-1:0] line_len, pol_line_len;
   logic [VS_W-1:0] frame_lines, pol_frame_lines;

   dvi_timing_rx #(
      .H_RES(H_RES), .V_RES(V_RES), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOCK_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .display_on(display_on),
      .x(x), .y(y), .pixel_valid(pixel_valid), .line_start(line_start),
      .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines),
      .locked(locked), .timing_err(timing_err)
   );

   dvi_timing_rx #(
      .H_RES(H_RES), .V_RES(V_RES), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LOCK_FRAMES(2)
   ) dut_pol (
      .clk(clk), .rst(rst), .hsync(pol_hsync), .vsync(pol_vsync), .display_on(display_on),
      .x(pol_x), .y(pol_y), .pixel_valid(pol_pixel_valid), .line_start(pol_line_start),
      .frame_start(pol_frame_start), .line_len(pol_line_len), .frame_lines(pol_frame_lines),
      .locked(pol_locked), .timing_err(pol_timing_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Observation statistics, cleared on request between scenarios
   int fs_cnt = 0, lock_at = -1, te_cnt = 0, err_len = 0, err_fl = 0, fall_on_fs = 0;
   int max_x = 0, max_y = 0, first_x = -1, first_y = -1, pv_cnt = 0;
   int pol_fs_cnt = 0, pol_lock_at = -1;
   logic locked_q = 1'b0, pol_locked_q = 1'b0;

   always @(negedge clk) begin
      if (clr) begin
         fs_cnt = 0; lock_at = -1; te_cnt = 0; err_len = 0; err_fl = 0; fall_on_fs = 0;
         max_x = 0; max_y = 0; first_x = -1; first_y = -1; pv_cnt = 0;
         pol_fs_cnt = 0; pol_lock_at = -1;
      end else begin
         if (frame_start) fs_cnt++;
         if (locked && !locked_q) lock_at = fs_cnt;
         if (!locked && locked_q && frame_start) fall_on_fs = 1;
         if (timing_err) begin
            te_cnt++;
            err_len = int'(line_len);
            err_fl  = int'(frame_lines);
         end
         if (pixel_valid) begin
            pv_cnt++;
            if (first_x < 0) begin
               first_x = int'(x);
               first_y = int'(y);
            end
            if (int'(x) > max_x) max_x = int'(x);
            if (int'(y) > max_y) max_y = int'(y);
         end
         if (pol_frame_start) pol_fs_cnt++;
         if (pol_locked && !pol_locked_q) pol_lock_at = pol_fs_cnt;
      end
      locked_q     = locked;
      pol_locked_q = pol_locked;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input logic hs, input logic vs, input logic de);
      hsync      = hs;
      vsync      = vs;
      display_on = de;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      clr = 1'b1;
      @(negedge clk);
      #1;
      clr = 1'b0;
   endtask

   // One frame of nlines lines; line short_l is one clock short; stop after stop_at ticks if >= 0.
   // hsync low for p 0..2, vsync edge at line 0 pixel 4, active window lines 2..9, pixels 5..20.
   task automatic run_frame(input int nlines, input int short_l, input int stop_at);
      int n;
      int len;
      n = 0;
      for (int l = 0; l < nlines; l++) begin
         len = (l == short_l) ? H_TOTAL - 1 : H_TOTAL;
         for (int p = 0; p < len; p++) begin
            if (stop_at >= 0 && n == stop_at) return;
            tick(p >= 3,
                 !((l == 0 && p >= 4) || (l == 1 && p < 4)),
                 (l >= 2 && l < 2 + V_RES && p >= 5 && p < 5 + H_RES));
            n++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; hsync = 1'b1; vsync = 1'b1; display_on = 1'b0; inv = 1'b0; clr = 1'b0;
      repeat (3) tick(1'b1, 1'b1, 1'b0);
      check("reset_outs", 32'({x, y, pixel_valid, line_start, frame_start, line_len,
                               frame_lines, locked, timing_err}), 32'd0);
      rst = 1'b0;

      // Clean raster from reset
      clear_stats();
      repeat (3) run_frame(V_TOTAL, -1, -1);
      check("clean_lock_at", lock_at, 3);
      check("clean_locked", locked, 1);
      check("pol_lock_at", pol_lock_at, 3);
      check("first_x", first_x, 0);
      check("first_y", first_y, 0);
      check("max_x", max_x, H_RES - 1);
      check("max_y", max_y, V_RES - 1);
      check("pixel_count", pv_cnt, 3 * H_RES * V_RES);
      check("line_len", line_len, H_TOTAL);
      check("frame_lines", frame_lines, V_TOTAL);

      // One short line while locked
      clear_stats();
      run_frame(V_TOTAL, 5, -1);
      check("short_err_cnt", te_cnt, 1);
      check("short_err_len", err_len, H_TOTAL - 1);
      check("short_unlocked", locked, 0);
      clear_stats();
      repeat (3) run_frame(V_TOTAL, -1, -1);
      check("short_relock_at", lock_at, 3);
      check("short_relock_err", te_cnt, 0);

      // One frame with an extra line while locked
      clear_stats();
      run_frame(V_TOTAL + 1, -1, -1);
      run_frame(V_TOTAL, -1, -1);
      check("long_err_cnt", te_cnt, 1);
      check("long_err_lines", err_fl, V_TOTAL + 1);
      check("long_drop_on_edge", fall_on_fs, 1);
      check("long_unlocked", locked, 0);
      repeat (2) run_frame(V_TOTAL, -1, -1);
      check("long_relocked", locked, 1);

      // hsync absent for longer than 2*H_TOTAL clocks
      clear_stats();
      repeat (2 * H_TOTAL + 10) tick(1'b1, 1'b1, 1'b0);
      check("lost_err_cnt", te_cnt, 1);
      check("lost_unlocked", locked, 0);
      clear_stats();
      repeat (3) run_frame(V_TOTAL, -1, -1);
      check("lost_relock_at", lock_at, 3);

      // Polarity-mismatched syncs on the positive-polarity instance
      inv = 1'b1;
      repeat (4) run_frame(V_TOTAL, -1, -1);
      check("inv_locked", pol_locked, 1);
      check("inv_line_len", pol_line_len, H_TOTAL);
      check("inv_frame_lines", pol_frame_lines, V_TOTAL);
      check("inv_main_locked", locked, 1);
      inv = 1'b0;

      // Reset mid-line while locked, inside the active window
      repeat (2) run_frame(V_TOTAL, -1, -1);
      run_frame(V_TOTAL, -1, 5 * H_TOTAL + 10);
      check("pre_rst_locked", locked, 1);
      check("pre_rst_valid", pixel_valid, 1);
      rst = 1'b1;
      tick(1'b1, 1'b1, 1'b0);
      check("rst_outs", 32'({x, y, pixel_valid, line_start, frame_start, line_len,
                             frame_lines, locked, timing_err}), 32'd0);
      rst = 1'b0;
      clear_stats();
      repeat (3) run_frame(V_TOTAL, -1, -1);
      check("rst_relock_at", lock_at, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
